// File: rtl/chain_lockstep_checker_if.sv
// Handshake bundle between the lockstep checker and its environment.
// The slave modport is the checker side; the master modport is the driver side.
interface chain_lockstep_checker_if #(
  parameter int NUM_LANES = 4,
  parameter int CNT_W     = 8
);
  logic                 en;
  logic                 clear;
  logic                 ref_in;
  logic [NUM_LANES-1:0] lane_in;
  logic                 voted;
  logic [NUM_LANES-1:0] mismatch_mask;
  logic                 fault;
  logic [NUM_LANES-1:0] fault_lane;
  logic [CNT_W-1:0]     err_cnt;
  logic [2:0]           state;

  modport master (
    output en, clear, ref_in, lane_in,
    input  voted, mismatch_mask, fault, fault_lane, err_cnt, state
  );

  modport slave (
    input  en, clear, ref_in, lane_in,
    output voted, mismatch_mask, fault, fault_lane, err_cnt, state
  );
endinterface

// File: rtl/chain_lockstep_checker.sv
// Two-stage capture, majority vote and persistent-divergence detector for replicated chains.
// Define CHAIN_CHK_STICKY_MASK_EN to make fault_lane accumulate every diverging lane until clear.
module chain_lockstep_checker #(
  parameter int NUM_LANES = 4,
  parameter int PERSIST   = 3,
  parameter int SETTLE    = 2,
  parameter int CNT_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  chain_lockstep_checker_if.slave  bus
);
  // state   | meaning
  // IDLE    | monitoring disabled
  // SETTLE  | flushing the capture pipeline after enable
  // MONITOR | lanes agree with the reference
  // SUSPECT | divergence seen, counting consecutive samples
  // FAULT   | persistent divergence, held until clear
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_MONITOR = 3'd2,
    S_SUSPECT = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  localparam int RUN_W  = $clog2(PERSIST + 1);
  localparam int SET_W  = $clog2(SETTLE + 1);
  localparam int ONES_W = $clog2(NUM_LANES + 1);
  localparam logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}};

  state_t               state_q, state_d;
  logic [NUM_LANES-1:0] lane_q, lane_d;
  logic                 ref_q, ref_d;
  logic [NUM_LANES-1:0] mm_q, mm_d;
  logic                 voted_q, voted_d;
  logic [SET_W-1:0]     settle_q, settle_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic                 fault_q, fault_d;
  logic [NUM_LANES-1:0] fault_lane_q, fault_lane_d;
  logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
  logic [ONES_W-1:0]    ones;
  logic                 any_mm;
  logic                 err_inc;

  always_comb begin
    lane_d = bus.lane_in;
    ref_d  = bus.ref_in;
    mm_d   = lane_q ^ {NUM_LANES{ref_q}};

    ones = '0;
    for (int i = 0; i < NUM_LANES; i++) ones = ones + ONES_W'(lane_q[i]);
    // Compare 2*ones against the lane count so only an exact half split is a tie.
    if (2 * int'(ones) > NUM_LANES)      voted_d = 1'b1;
    else if (2 * int'(ones) < NUM_LANES) voted_d = 1'b0;
    else                                 voted_d = ref_q;

    any_mm       = |mm_q;
    state_d      = state_q;
    settle_d     = settle_q;
    run_d        = run_q;
    fault_d      = fault_q;
    fault_lane_d = fault_lane_q;
    err_inc      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.en) begin
          state_d  = S_SETTLE;
          settle_d = SET_W'(SETTLE);
        end
      end
      S_SETTLE: begin
        if (!bus.en) begin
          state_d = S_IDLE;
          run_d   = '0;
        end else if (settle_q == SET_W'(1)) begin
          state_d = S_MONITOR;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      S_MONITOR: begin
        if (!bus.en) begin
          state_d = S_IDLE;
          run_d   = '0;
        end else if (any_mm) begin
          err_inc = 1'b1;
          run_d   = RUN_W'(1);
          if (PERSIST == 1) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
          end else begin
            state_d = S_SUSPECT;
          end
        end
      end
      S_SUSPECT: begin
        if (!bus.en) begin
          state_d = S_IDLE;
          run_d   = '0;
        end else if (any_mm) begin
          err_inc = 1'b1;
          run_d   = run_q + RUN_W'(1);
          if (run_q + RUN_W'(1) == RUN_W'(PERSIST)) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
          end
        end else begin
          state_d = S_MONITOR;
          run_d   = '0;
        end
      end
      S_FAULT: begin
        fault_d = 1'b1;
        err_inc = any_mm;
      end
      default: state_d = S_IDLE;
    endcase

    err_cnt_d = (err_inc && err_cnt_q != ERR_MAX) ? err_cnt_q + CNT_W'(1) : err_cnt_q;

`ifdef CHAIN_CHK_STICKY_MASK_EN
    if (((state_q == S_MONITOR || state_q == S_SUSPECT) && bus.en) || state_q == S_FAULT)
      fault_lane_d = fault_lane_q | mm_q;
`else
    if (state_d == S_FAULT && state_q != S_FAULT)
      fault_lane_d = mm_q;
`endif

    // Clear beats everything above, including a same-cycle increment.
    if (bus.clear) begin
      state_d      = S_IDLE;
      settle_d     = '0;
      run_d        = '0;
      fault_d      = 1'b0;
      fault_lane_d = '0;
      err_cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lane_q       <= '0;
      ref_q        <= 1'b0;
      mm_q         <= '0;
      voted_q      <= 1'b0;
      settle_q     <= '0;
      run_q        <= '0;
      fault_q      <= 1'b0;
      fault_lane_q <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      ref_q        <= ref_d;
      mm_q         <= mm_d;
      voted_q      <= voted_d;
      settle_q     <= settle_d;
      run_q        <= run_d;
      fault_q      <= fault_d;
      fault_lane_q <= fault_lane_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bus.voted         = voted_q;
  assign bus.mismatch_mask = mm_q;
  assign bus.fault         = fault_q;
  assign bus.fault_lane    = fault_lane_q;
  assign bus.err_cnt       = err_cnt_q;
  assign bus.state         = state_q;
endmodule

// File: tb/tb_chain_lockstep_checker.sv
// Directed bench for chain_lockstep_checker at default parameters.
module tb_chain_lockstep_checker;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  chain_lockstep_checker_if #(.NUM_LANES(4), .CNT_W(8)) bus ();

  chain_lockstep_checker #(
    .NUM_LANES(4), .PERSIST(3), .SETTLE(2), .CNT_W(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  logic prev_ref = 1'b0;

  logic [2:0] stk_st  [6] = '{3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4};
  logic [3:0] stk_mm  [6] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0};
  logic [7:0] stk_err [6] = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd3};
  logic [2:0] gl_st   [5] = '{3'd2, 3'd2, 3'd3, 3'd3, 3'd2};
  logic [3:0] gl_mm   [5] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h0};
  logic [7:0] gl_err  [5] = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd2};
  logic [2:0] rc_st   [5] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd3};
  logic [7:0] rc_err  [5] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a reference bit with a minority of lanes flipped; voted must track ref two edges late.
  task automatic step(input logic r, input logic [3:0] flip, input string tag);
    bus.ref_in  = r;
    bus.lane_in = {4{r}} ^ flip;
    tick();
    chk({tag, "_voted"}, 32'(bus.voted), 32'(prev_ref));
    prev_ref = r;
  endtask

  initial begin
    rst         = 1'b1;
    bus.en      = 1'($urandom_range(0, 1));
    bus.clear   = 1'($urandom_range(0, 1));
    bus.ref_in  = 1'($urandom_range(0, 1));
    bus.lane_in = 4'($urandom_range(0, 15));
    tick();
    bus.en      = 1'($urandom_range(0, 1));
    bus.ref_in  = 1'($urandom_range(0, 1));
    bus.lane_in = 4'($urandom_range(0, 15));
    tick();
    chk("rst_voted", 32'(bus.voted), 0);
    chk("rst_mask", 32'(bus.mismatch_mask), 0);
    chk("rst_fault", 32'(bus.fault), 0);
    chk("rst_fault_lane", 32'(bus.fault_lane), 0);
    chk("rst_err", 32'(bus.err_cnt), 0);
    chk("rst_state", 32'(bus.state), 0);

    rst       = 1'b0;
    bus.clear = 1'b0;
    bus.en    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1'($urandom_range(0, 1)), 4'b0000, "clean");
      chk("clean_state", 32'(bus.state), (i < 2) ? 1 : 2);
      chk("clean_mask", 32'(bus.mismatch_mask), 0);
    end
    chk("clean_err", 32'(bus.err_cnt), 0);
    chk("clean_fault", 32'(bus.fault), 0);

    for (int s = 0; s < 6; s++) begin
      step(1'($urandom_range(0, 1)), (s < 3) ? 4'b0100 : 4'b0000, "stuck");
      chk("stuck_state", 32'(bus.state), 32'(stk_st[s]));
      chk("stuck_mask", 32'(bus.mismatch_mask), 32'(stk_mm[s]));
      chk("stuck_err", 32'(bus.err_cnt), 32'(stk_err[s]));
      chk("stuck_fault", 32'(bus.fault), (s >= 4) ? 1 : 0);
    end
    chk("stuck_fault_lane", 32'(bus.fault_lane), 32'h4);

    bus.clear = 1'b1;
    step(1'($urandom_range(0, 1)), 4'b0000, "clr1");
    chk("clr1_state", 32'(bus.state), 0);
    chk("clr1_fault", 32'(bus.fault), 0);
    chk("clr1_err", 32'(bus.err_cnt), 0);
    chk("clr1_fault_lane", 32'(bus.fault_lane), 0);
    bus.clear = 1'b0;
    for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)), 4'b0000, "resettle");
    chk("resettle_state", 32'(bus.state), 2);

    for (int s = 0; s < 5; s++) begin
      step(1'($urandom_range(0, 1)), (s < 2) ? 4'b0001 : 4'b0000, "glitch");
      chk("glitch_state", 32'(bus.state), 32'(gl_st[s]));
      chk("glitch_mask", 32'(bus.mismatch_mask), 32'(gl_mm[s]));
      chk("glitch_err", 32'(bus.err_cnt), 32'(gl_err[s]));
      chk("glitch_fault", 32'(bus.fault), 0);
    end
`ifdef CHAIN_CHK_STICKY_MASK_EN
    chk("glitch_fault_lane", 32'(bus.fault_lane), 32'h1);
`else
    chk("glitch_fault_lane", 32'(bus.fault_lane), 32'h0);
`endif

    for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 1)), 4'b0010, "sat");
    chk("sat_err", 32'(bus.err_cnt), 255);
    chk("sat_state", 32'(bus.state), 4);
    chk("sat_fault", 32'(bus.fault), 1);
`ifdef CHAIN_CHK_STICKY_MASK_EN
    chk("sat_fault_lane", 32'(bus.fault_lane), 32'h3);
`else
    chk("sat_fault_lane", 32'(bus.fault_lane), 32'h2);
`endif
    for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)), 4'b0010, "sat_hold");
    chk("sat_hold_err", 32'(bus.err_cnt), 255);

    bus.clear = 1'b1;
    step(1'($urandom_range(0, 1)), 4'b0010, "clr2");
    chk("clr2_state", 32'(bus.state), 0);
    chk("clr2_err", 32'(bus.err_cnt), 0);
    chk("clr2_fault", 32'(bus.fault), 0);
    chk("clr2_fault_lane", 32'(bus.fault_lane), 0);
    bus.clear = 1'b0;

    for (int s = 0; s < 5; s++) begin
      step(1'($urandom_range(0, 1)), 4'b0010, "recount");
      chk("recount_state", 32'(bus.state), 32'(rc_st[s]));
      chk("recount_err", 32'(bus.err_cnt), 32'(rc_err[s]));
    end
    bus.clear = 1'b1;
    step(1'($urandom_range(0, 1)), 4'b0010, "clr3");
    chk("clr3_err", 32'(bus.err_cnt), 0);
    chk("clr3_state", 32'(bus.state), 0);
    bus.clear = 1'b0;

    bus.en      = 1'b0;
    bus.ref_in  = 1'b1;
    bus.lane_in = 4'b0011;
    tick();
    tick();
    chk("tie1_voted", 32'(bus.voted), 1);
    chk("tie1_mask", 32'(bus.mismatch_mask), 32'hC);
    chk("tie1_state", 32'(bus.state), 0);
    bus.ref_in = 1'b0;
    tick();
    tick();
    chk("tie0_voted", 32'(bus.voted), 0);
    chk("tie0_mask", 32'(bus.mismatch_mask), 32'h3);
    bus.lane_in = 4'b0111;
    tick();
    tick();
    chk("maj1_voted", 32'(bus.voted), 1);
    chk("maj1_mask", 32'(bus.mismatch_mask), 32'h7);
    bus.ref_in  = 1'b1;
    bus.lane_in = 4'b0001;
    tick();
    tick();
    chk("maj0_voted", 32'(bus.voted), 0);
    chk("maj0_mask", 32'(bus.mismatch_mask), 32'hE);
    chk("idle_err", 32'(bus.err_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/chain_lockstep_checker.md
Name: chain_lockstep_checker

Overview:
- Capture stage directly downstream of replicated buffer/inverter chains driven from a common source net.
- Registers each chain output alongside the pre-chain reference, majority-votes the lanes and flags lanes that diverge from the reference.
- Declares a fault after persistent divergence, so equivalence of swapped or replaced chain implementations is checked in hardware.

Parameters:
- NUM_LANES, 4, number of chain outputs compared (min 2).
- PERSIST, 3, consecutive mismatching samples needed to declare a fault (min 1).
- SETTLE, 2, cycles ignored after enable to flush the pipeline (min 1).
- CNT_W, 8, mismatch counter width.

Ports:
- clk  in  1  single clock, all state on the rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  monitoring enable.
- clear  in  1  synchronous fault/counter clear.
- ref_in  in  1  pre-chain source signal.
- lane_in  in  NUM_LANES  chain outputs, one bit per lane.
- voted  out  1  majority of registered lanes.
- mismatch_mask  out  NUM_LANES  per-lane disagreement with reference.
- fault  out  1  persistent divergence detected.
- fault_lane  out  NUM_LANES  lanes implicated in the fault.
- err_cnt  out  CNT_W  saturating count of mismatching cycles.
- state  out  3  FSM state: IDLE=0, SETTLE=1, MONITOR=2, SUSPECT=3, FAULT=4.

Behaviour:
- Reset:
  - rst=1 zeroes both pipeline stages and all outputs; state=IDLE.
  - rst dominates clear and en.
- Stage 1 (every edge, independent of en): lane_q<=lane_in, ref_q<=ref_in.
- Stage 2 (every edge):
  - mm_q <= lane_q XOR {NUM_LANES{ref_q}}.
  - voted <= 1 when ones(lane_q) > NUM_LANES/2; 0 when ones(lane_q) < NUM_LANES/2; ref_q on a tie.
  - mismatch_mask = mm_q, and any_mm = OR of mm_q.
  - Input-to-voted/mismatch_mask latency is 2 edges.
- FSM and counters:
  - IDLE: en=1 -> SETTLE, settle counter loaded with SETTLE.
  - SETTLE: decrement each edge; any_mm is ignored and not counted; after exactly SETTLE cycles -> MONITOR.
  - MONITOR: any_mm=1 -> run_next=1; if run_next==PERSIST -> FAULT, else -> SUSPECT with run=1.
  - SUSPECT: any_mm=1 -> run+1, -> FAULT when it reaches PERSIST; any_mm=0 -> MONITOR, run=0.
  - FAULT: sets fault=1 and holds regardless of en; leaves only on clear (-> IDLE).
  - en=0 in IDLE/SETTLE/MONITOR/SUSPECT -> IDLE next edge, run=0; err_cnt and fault_lane hold.
  - clear in any state -> IDLE, fault=0, fault_lane=0, err_cnt=0, run=0. Clear wins over a coincident mismatch increment.
- Fault timing: fault rises after edge e0+PERSIST+1, where e0 is the edge capturing the first of PERSIST consecutive mismatching samples (monitor already in MONITOR).
- err_cnt:
  - +1 on each edge with any_mm=1 in MONITOR, SUSPECT or FAULT.
  - Saturates at 2^CNT_W-1 with no wrap.
- fault_lane: loaded with mm_q on the edge entering FAULT, then held.
- Mismatch on mixed lanes across consecutive cycles still counts as consecutive; any_mm is lane-agnostic.

Optional Feature:
- Macro: CHAIN_CHK_STICKY_MASK_EN.
- Defined: fault_lane <= fault_lane OR mm_q on every edge in MONITOR, SUSPECT or FAULT. It accumulates every lane ever seen diverging until clear/rst, and may be nonzero while fault=0.
- Undefined: fault_lane is a snapshot at FAULT entry, as above.

Test Plan (defaults NUM_LANES=4, PERSIST=3, SETTLE=2, CNT_W=8):
- Reset: rst=1 for 2 cycles with random inputs -> voted=0, mismatch_mask=0, fault=0, fault_lane=0, err_cnt=0, state=0.
- Clean run: en=1, all lanes=ref_in toggling for 20 cycles -> state 1 for 2 cycles then 2; voted equals ref_in delayed 2 edges; err_cnt=0; fault=0.
- Stuck lane: lane2=~ref_in for 3 consecutive samples starting at e0 -> mismatch_mask=4'b0100 after e0+2; state 3 then 4; fault=1 after e0+4; fault_lane=4'b0100; err_cnt=3 thereafter; voted still equals ref.
- Glitch: lane0 wrong for 2 samples -> state 2->3->3->2; fault=0; err_cnt=2. In sticky build, fault_lane=4'b0001.
- Saturation and clear: lane1 stuck for 300 cycles -> err_cnt=255 and holds; pulse clear -> next edge err_cnt=0, fault=0, state=0. Clear coincident with a mismatch -> err_cnt=0.
- Tie break: lanes=4'b0011 with ref_in=1 -> voted=1; same lanes with ref_in=0 -> voted=0; mismatch_mask=4'b1100 and 4'b0011 respectively.
